// File: rtl/ham_7_4_pkg.sv
// -----------------------------------------------------------------------------
// ham_7_4_pkg
// Shared definitions for the serial Hamming(7,4) encoder.
//   - codeword / data lengths and the parity bit positions
//   - state enum of the output serializer (IDLE, SEND, GAP)
//   - ham_build_cw(): builds the 7-bit codeword from d1..d4. The decoder's
//     bench model can reuse it.
// Codeword bit order: index CW_LEN-1 holds position 1 (sent first) and index
// 0 holds position 7 (sent last). This lets the serializer shift left and
// always drive its MSB.
// Optional feature macro used by the top level: HAM_ENC_OVERRUN_DETECT_EN.
// -----------------------------------------------------------------------------
package ham_7_4_pkg;

  localparam int unsigned CW_LEN   = 7;
  localparam int unsigned DATA_LEN = 4;

  // 1-based codeword positions of the parity bits
  localparam int unsigned P1_POS = 1;
  localparam int unsigned P2_POS = 2;
  localparam int unsigned P4_POS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } ser_state_e;

  // Positions 1..7 = p1, p2, d1, p4, d2, d3, d4. Each parity bit covers the
  // data positions whose 1-based index has that parity's bit set. A single
  // flipped bit therefore yields a syndrome equal to its position.
  function automatic logic [CW_LEN-1:0] ham_build_cw(
    input logic d1,
    input logic d2,
    input logic d3,
    input logic d4
  );
    logic p1;
    logic p2;
    logic p4;
    p1 = d1 ^ d2 ^ d4;
    p2 = d1 ^ d3 ^ d4;
    p4 = d2 ^ d3 ^ d4;
    return {p1, p2, d1, p4, d2, d3, d4};
  endfunction

endpackage

// File: rtl/ham_7_4_enc_ser.sv
// -----------------------------------------------------------------------------
// ham_7_4_ser
// Output side of the Hamming(7,4) encoder. It holds a shift register, the
// IDLE/SEND/GAP state machine and the bit and gap counters. A codeword
// offered on word_i with load_i high is taken on the next edge whenever the
// serializer can start a new word (busy_o low). The word is then sent MSB
// first with dvout_o low for exactly CW_LEN consecutive cycles.
//
// Parameters:
//   IDLE_GAP  minimum dvout-high cycles between codewords (0..7)
// Ports:
//   clk       clock; all state changes on its rising edge
//   reset     asynchronous, active-low reset
//   word_i    codeword to send, position 1 in the MSB
//   load_i    a word is waiting on word_i
//   busy_o    high = a load_i would be ignored this cycle
//   code_o    serial codeword bit, registered; 0 while dvout_o is high
//   dvout_o   active-low output valid, registered
// -----------------------------------------------------------------------------
module ham_7_4_ser
  import ham_7_4_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CW_LEN-1:0] word_i,
  input  logic              load_i,
  output logic              busy_o,
  output logic              code_o,
  output logic              dvout_o
);

  localparam logic [2:0] OCNT_LAST = 3'(CW_LEN - 1);
  localparam bit         GAP_EN    = (IDLE_GAP > 0);
  localparam logic [2:0] GAP_LAST  = GAP_EN ? 3'(IDLE_GAP - 1) : 3'd0;

  ser_state_e        state_q;
  ser_state_e        state_d;
  logic [CW_LEN-1:0] shift_q;
  logic [CW_LEN-1:0] shift_d;
  logic [2:0]        ocnt_q;
  logic [2:0]        ocnt_d;
  logic [2:0]        gcnt_q;
  logic [2:0]        gcnt_d;
  logic              code_q;
  logic              code_d;
  logic              dvout_q;
  logic              dvout_d;
  logic              ready;

  // A new word may start from IDLE. It may also start on the edge that ends
  // the last gap cycle, or, without a gap, on the edge that ends bit 7. Those
  // two cases keep the minimum spacing exact instead of adding an IDLE cycle.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      SEND:    ready = !GAP_EN && (ocnt_q == OCNT_LAST);
      GAP:     ready = (gcnt_q == GAP_LAST);
      default: ready = 1'b0;
    endcase
  end

  assign busy_o = !ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    ocnt_d  = ocnt_q;
    gcnt_d  = gcnt_q;

    if (load_i && ready) begin
      state_d = SEND;
      shift_d = word_i;
      ocnt_d  = 3'd0;
      gcnt_d  = 3'd0;
    end else begin
      case (state_q)
        SEND: begin
          if (ocnt_q == OCNT_LAST) begin
            ocnt_d  = 3'd0;
            gcnt_d  = 3'd0;
            shift_d = '0;
            state_d = GAP_EN ? GAP : IDLE;
          end else begin
            ocnt_d  = ocnt_q + 3'd1;
            shift_d = {shift_q[CW_LEN-2:0], 1'b0};
          end
        end
        GAP: begin
          if (gcnt_q == GAP_LAST) begin
            state_d = IDLE;
          end else begin
            gcnt_d = gcnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end

    // The output stage registers the head of the shift register. The line
    // therefore trails the state by one edge and dvout stays low for
    // exactly the CW_LEN cycles spent in SEND.
    dvout_d = (state_q != SEND);
    code_d  = (state_q == SEND) ? shift_q[CW_LEN-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      ocnt_q  <= 3'd0;
      gcnt_q  <= 3'd0;
      code_q  <= 1'b0;
      dvout_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      ocnt_q  <= ocnt_d;
      gcnt_q  <= gcnt_d;
      code_q  <= code_d;
      dvout_q <= dvout_d;
    end
  end

  assign code_o  = code_q;
  assign dvout_o = dvout_q;

endmodule

// File: rtl/ham_7_4_enc.sv
// -----------------------------------------------------------------------------
// ham_7_4_enc
// Serial Hamming(7,4) encoder. It collects 4 data bits from an active-low
// valid serial stream and keeps one finished word in a pending buffer. Each
// word is handed to the serializer as a 7-bit codeword, which is sent as
// p1, p2, d1, p4, d2, d3, d4 with an active-low valid. A new word can be
// collected while the previous one is shifting out. rdy back-pressures the
// source once a word is pending and the next one is also complete except for
// its last bit.
//
// Parameters:
//   IDLE_GAP  minimum dvout-high cycles between codewords (0..7)
// Ports:
//   clk       clock; all state changes on its rising edge
//   reset     asynchronous, active-low reset
//   datain    serial data bit, sampled when dvin=0 and rdy=1
//   dvin      active-low input valid, one bit per low cycle
//   rdy       high = a bit is accepted this cycle (combinational)
//   code      serial codeword bit, registered
//   dvout     active-low output valid, registered
//   ovf       (only with HAM_ENC_OVERRUN_DETECT_EN) sticky flag; set after
//             any cycle with dvin=0 and rdy=0; cleared only by reset
// Optional feature macro: HAM_ENC_OVERRUN_DETECT_EN
// -----------------------------------------------------------------------------
module ham_7_4_enc
  import ham_7_4_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic datain,
  input  logic dvin,
  output logic rdy,
  output logic code,
  output logic dvout
`ifdef HAM_ENC_OVERRUN_DETECT_EN
  ,
  output logic ovf
`endif
);

  logic [1:0]          ccnt_q;
  logic [1:0]          ccnt_d;
  // Only d1..d3 need storage. d4 goes straight from datain into the pending
  // buffer on the edge that completes the word.
  logic [DATA_LEN-2:0] coll_q;
  logic [DATA_LEN-2:0] coll_d;
  logic [DATA_LEN-1:0] pend_q;       // index 0 = d1
  logic [DATA_LEN-1:0] pend_d;
  logic                pend_v_q;
  logic                pend_v_d;

  logic                accept;
  logic                word_done;
  logic                load;
  logic                ser_busy;
  logic [CW_LEN-1:0]   pend_cw;

  // Conservative: rdy stays low through the cycle in which the pending word
  // is consumed and rises on the next one.
  assign rdy       = !(pend_v_q && (ccnt_q == 2'd3));
  assign accept    = !dvin && rdy;
  assign word_done = accept && (ccnt_q == 2'd3);
  assign load      = pend_v_q && !ser_busy;

  for (genvar gi = 0; gi < DATA_LEN - 1; gi++) begin : g_coll
    assign coll_d[gi] = (accept && (ccnt_q == 2'(gi))) ? datain : coll_q[gi];
  end

  always_comb begin
    ccnt_d   = accept ? ccnt_q + 2'd1 : ccnt_q;
    pend_d   = word_done ? {datain, coll_q} : pend_q;
    // Setting wins over clearing: a word completed on the load edge moves
    // into the buffer that the load just freed.
    pend_v_d = word_done ? 1'b1 : (load ? 1'b0 : pend_v_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ccnt_q   <= 2'd0;
      coll_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      ccnt_q   <= ccnt_d;
      coll_q   <= coll_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  assign pend_cw = ham_build_cw(pend_q[0], pend_q[1], pend_q[2], pend_q[3]);

  ham_7_4_ser #(
    .IDLE_GAP (IDLE_GAP)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .word_i  (pend_cw),
    .load_i  (pend_v_q),
    .busy_o  (ser_busy),
    .code_o  (code),
    .dvout_o (dvout)
  );

`ifdef HAM_ENC_OVERRUN_DETECT_EN
  logic ovf_q;
  logic ovf_d;

  assign ovf_d = ovf_q | (!dvin && !rdy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
